constraint_sample_driver: RTL and testbench

// Stimulus-side counterpart of the generated constraint checkers. It produces pseudo-random

---
 rtl/constraint_sample_driver.sv | 164 ++++++++++++++++
 tb/tb_constraint_sample_driver.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/constraint_sample_driver.sv
// Pseudo-random candidate generator for the constraint checkers: fills cand from a Galois LFSR,
// waits for the checker verdict and streams accepted candidates out over a valid/ready port.
module constraint_sample_driver #(
  parameter int unsigned VEC_W     = 64,
  parameter logic [31:0] SEED      = 32'hACE1_2024,
  parameter int unsigned MAX_TRIES = 1024,
  parameter int unsigned CHK_LAT   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [15:0]      req_count,
  input  logic             seed_load,
  input  logic [31:0]      seed_in,
  output logic [VEC_W-1:0] cand,
  input  logic             chk_ok,
  output logic             smp_valid,
  input  logic             smp_ready,
  output logic [VEC_W-1:0] smp_data,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [15:0]      tries
);

  localparam int unsigned NW   = (VEC_W + 32'd31) / 32'd32;
  localparam int unsigned WC_W = (NW > 32'd1) ? $clog2(NW) : 32'd1;
  localparam int unsigned LC_W = (CHK_LAT > 32'd0) ? $clog2(CHK_LAT + 32'd1) : 32'd1;

  localparam logic [31:0]     TAPS      = 32'h8020_0003;
  localparam logic [WC_W-1:0] WORD_LAST = WC_W'(NW - 32'd1);
  localparam logic [LC_W-1:0] LAT_LAST  = LC_W'(CHK_LAT);
  localparam logic [15:0]     TRY_LAST  = 16'(MAX_TRIES - 32'd1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    CHECK = 2'd2,
    EMIT  = 2'd3
  } state_t;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ({1'b0, s[31:1]} ^ TAPS) : {1'b0, s[31:1]};
  endfunction

  state_t            state_r;
  logic [31:0]       lfsr_r;
  logic [VEC_W-1:0]  cand_r;
  logic [VEC_W-1:0]  smp_data_r;
  logic              smp_valid_r;
  logic              busy_r;
  logic              done_r;
  logic              fail_r;
  logic [15:0]       tries_r;
  logic [15:0]       remaining_r;
  logic [WC_W-1:0]   word_cnt_r;
  logic [LC_W-1:0]   lat_cnt_r;

  logic [31:0]       lfsr_next_s;
  logic [VEC_W+31:0] shift_s;
  logic [VEC_W-1:0]  cand_next_s;
  logic [31:0]       seed_pick_s;

  // New word enters at the bottom, so the first word of a fill ends up in the top bits.
  assign lfsr_next_s = lfsr_step(lfsr_r);
  assign shift_s     = {cand_r, lfsr_next_s};
  assign cand_next_s = shift_s[VEC_W-1:0];
  assign seed_pick_s = (seed_in == 32'd0) ? SEED : seed_in;

  // Request sequencer: seed load / start in IDLE, fill, checker wait, sample emit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      lfsr_r      <= SEED;
      cand_r      <= '0;
      smp_data_r  <= '0;
      smp_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      fail_r      <= 1'b0;
      tries_r     <= 16'd0;
      remaining_r <= 16'd0;
      word_cnt_r  <= '0;
      lat_cnt_r   <= '0;
    end else begin
      done_r <= 1'b0;
      fail_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (seed_load) begin
            lfsr_r <= seed_pick_s;
          end else if (start && (req_count != 16'd0)) begin
            remaining_r <= req_count;
            tries_r     <= 16'd0;
            word_cnt_r  <= '0;
            busy_r      <= 1'b1;
            state_r     <= FILL;
          end
        end
        FILL: begin
          lfsr_r <= lfsr_next_s;
          cand_r <= cand_next_s;
          if (word_cnt_r == WORD_LAST) begin
            word_cnt_r <= '0;
            lat_cnt_r  <= '0;
            state_r    <= CHECK;
          end else begin
            word_cnt_r <= word_cnt_r + WC_W'(1);
          end
        end
        CHECK: begin
          // chk_ok is only trusted once the checker pipe has seen the final cand.
          if (lat_cnt_r == LAT_LAST) begin
            lat_cnt_r <= '0;
            if (chk_ok) begin
              smp_data_r  <= cand_r;
              smp_valid_r <= 1'b1;
              state_r     <= EMIT;
            end else if (tries_r == TRY_LAST) begin
              fail_r      <= 1'b1;
              remaining_r <= 16'd0;
              tries_r     <= 16'd0;
              busy_r      <= 1'b0;
              state_r     <= IDLE;
            end else begin
              tries_r <= tries_r + 16'd1;
              state_r <= FILL;
            end
          end else begin
            lat_cnt_r <= lat_cnt_r + LC_W'(1);
          end
        end
        EMIT: begin
          if (smp_ready) begin
            smp_valid_r <= 1'b0;
            tries_r     <= 16'd0;
            remaining_r <= remaining_r - 16'd1;
            if (remaining_r == 16'd1) begin
              done_r  <= 1'b1;
              busy_r  <= 1'b0;
              state_r <= IDLE;
            end else begin
              state_r <= FILL;
            end
          end
        end
        default: begin
          smp_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign cand      = cand_r;
  assign smp_data  = smp_data_r;
  assign smp_valid = smp_valid_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign fail      = fail_r;
  assign tries     = tries_r;

endmodule

// File: tb/tb_constraint_sample_driver.sv
// Bench for constraint_sample_driver: two instances (combinational and 2-deep checker) compared
// every cycle against a transaction-level model, plus literal expectations for known seeds.
module tb_constraint_sample_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        seed_load = 1'b0;
  logic        smp_ready = 1'b0;
  logic [15:0] req_count = 16'd0;
  logic [31:0] seed_in = 32'd0;
  int          mode = 0;

  logic [63:0] cand0, data0;
  logic [39:0] cand1, data1;
  logic        chk0, chk1, valid0, valid1, busy0, busy1, done0, done1, fail0, fail1;
  logic [15:0] tries0, tries1;
  logic        p1 = 1'b0, p2 = 1'b0;

  int compared = 0;
  int mismatched = 0;
  bit chk_en = 1'b0;
  int done_cnt[2], fail_cnt[2], vrise_cnt[2];
  bit prev_valid[2];

  always #5 clk = ~clk;

  // Candidate acceptance rules used by the stand-in checker.
  function automatic logic pred(input int m, input logic [63:0] c);
    case (m)
      0:       return 1'b1;
      1:       return 1'b0;
      2:       return c[0] == 1'b0;
      default: return c[1:0] == 2'b00;
    endcase
  endfunction

  assign chk0 = pred(mode, cand0);
  always @(posedge clk) begin
    p1 <= pred(mode, {24'd0, cand1});
    p2 <= p1;
  end
  assign chk1 = p2;

  constraint_sample_driver #(.VEC_W(64), .SEED(32'hACE1_2024), .MAX_TRIES(4), .CHK_LAT(0)) u0 (
    .clk(clk), .rst(rst), .start(start), .req_count(req_count), .seed_load(seed_load),
    .seed_in(seed_in), .cand(cand0), .chk_ok(chk0), .smp_valid(valid0), .smp_ready(smp_ready),
    .smp_data(data0), .busy(busy0), .done(done0), .fail(fail0), .tries(tries0));

  constraint_sample_driver #(.VEC_W(40), .SEED(32'h1357_9BDF), .MAX_TRIES(6), .CHK_LAT(2)) u1 (
    .clk(clk), .rst(rst), .start(start), .req_count(req_count), .seed_load(seed_load),
    .seed_in(seed_in), .cand(cand1), .chk_ok(chk1), .smp_valid(valid1), .smp_ready(smp_ready),
    .smp_data(data1), .busy(busy1), .done(done1), .fail(fail1), .tries(tries1));

  // ---------------- reference model ----------------
  function automatic int nw_of(input int i);
    return (i == 0) ? (64 + 31) / 32 : (40 + 31) / 32;
  endfunction
  function automatic int lat_of(input int i);
    return (i == 0) ? 0 : 2;
  endfunction
  function automatic int max_of(input int i);
    return (i == 0) ? 4 : 6;
  endfunction
  function automatic logic [31:0] seed_of(input int i);
    return (i == 0) ? 32'hACE1_2024 : 32'h1357_9BDF;
  endfunction
  function automatic logic [63:0] mask_of(input int i);
    return (i == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_00FF_FFFF_FFFF;
  endfunction
  function automatic logic [31:0] galois(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  logic [31:0] m_lfsr[2];
  logic [63:0] m_cand[2], m_data[2];
  bit          m_valid[2], m_busy[2], m_done[2], m_fail[2];
  int          m_tries[2], m_rem[2], m_k[2];

  task automatic model_reset(input int i);
    m_lfsr[i] = seed_of(i); m_cand[i] = 64'd0; m_data[i] = 64'd0;
    m_valid[i] = 1'b0; m_busy[i] = 1'b0; m_done[i] = 1'b0; m_fail[i] = 1'b0;
    m_tries[i] = 0; m_rem[i] = 0; m_k[i] = 0;
  endtask

  // m_k is the cycle index inside the current attempt: NW fill cycles then LAT+1 check cycles.
  task automatic model_step(input int i);
    m_done[i] = 1'b0;
    m_fail[i] = 1'b0;
    if (!m_busy[i]) begin
      if (seed_load) m_lfsr[i] = (seed_in == 32'd0) ? seed_of(i) : seed_in;
      else if (start && req_count != 16'd0) begin
        m_rem[i] = int'(req_count); m_tries[i] = 0; m_busy[i] = 1'b1; m_k[i] = 0;
      end
    end else if (m_valid[i]) begin
      if (smp_ready) begin
        m_valid[i] = 1'b0; m_tries[i] = 0; m_rem[i] = m_rem[i] - 1;
        if (m_rem[i] == 0) begin m_done[i] = 1'b1; m_busy[i] = 1'b0; end
        else m_k[i] = 0;
      end
    end else if (m_k[i] < nw_of(i)) begin
      m_lfsr[i] = galois(m_lfsr[i]);
      m_cand[i] = ((m_cand[i] << 32) | {32'd0, m_lfsr[i]}) & mask_of(i);
      m_k[i] = m_k[i] + 1;
    end else if (m_k[i] < nw_of(i) + lat_of(i)) begin
      m_k[i] = m_k[i] + 1;
    end else if (pred(mode, m_cand[i])) begin
      m_data[i] = m_cand[i]; m_valid[i] = 1'b1;
    end else if (m_tries[i] + 1 == max_of(i)) begin
      m_fail[i] = 1'b1; m_rem[i] = 0; m_tries[i] = 0; m_busy[i] = 1'b0;
    end else begin
      m_tries[i] = m_tries[i] + 1; m_k[i] = 0;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      for (int i = 0; i < 2; i++) begin
        if (rst) model_reset(i);
        else model_step(i);
      end
    end
  end

  // ---------------- checking ----------------
  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cycle_compare();
    logic [63:0] o_cand[2], o_data[2];
    logic [15:0] o_tries[2];
    logic        o_valid[2], o_busy[2], o_done[2], o_fail[2];
    o_cand[0] = cand0; o_cand[1] = {24'd0, cand1};
    o_data[0] = data0; o_data[1] = {24'd0, data1};
    o_tries[0] = tries0; o_tries[1] = tries1;
    o_valid[0] = valid0; o_valid[1] = valid1;
    o_busy[0] = busy0; o_busy[1] = busy1;
    o_done[0] = done0; o_done[1] = done1;
    o_fail[0] = fail0; o_fail[1] = fail1;
    for (int i = 0; i < 2; i++) begin
      cmp($sformatf("u%0d.cand", i), o_cand[i], m_cand[i]);
      cmp($sformatf("u%0d.smp_data", i), o_data[i], m_data[i]);
      cmp($sformatf("u%0d.smp_valid", i), 64'(o_valid[i]), 64'(m_valid[i]));
      cmp($sformatf("u%0d.busy", i), 64'(o_busy[i]), 64'(m_busy[i]));
      cmp($sformatf("u%0d.done", i), 64'(o_done[i]), 64'(m_done[i]));
      cmp($sformatf("u%0d.fail", i), 64'(o_fail[i]), 64'(m_fail[i]));
      cmp($sformatf("u%0d.tries", i), 64'(o_tries[i]), 64'(m_tries[i]));
      if (o_done[i]) done_cnt[i]++;
      if (o_fail[i]) fail_cnt[i]++;
      if (o_valid[i] && !prev_valid[i]) vrise_cnt[i]++;
      prev_valid[i] = o_valid[i];
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (chk_en) cycle_compare();
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy0 || busy1) && n < budget) begin step(); n++; end
    cmp("wait_idle.busy", {62'd0, busy0, busy1}, 64'd0);
  endtask

  task automatic wait_valid0(input int budget);
    int n = 0;
    while (!valid0 && n < budget) begin step(); n++; end
    cmp("wait_valid0", 64'(valid0), 64'd1);
  endtask

  initial begin
    int d0, d1, f0, f1, vr, mx0, mx1, n;
    bit saw_v;
    logic [63:0] hold_d, hold_c;

    #1 rst = 1'b1;
    step(); step();
    cmp("rst.cand", cand0, 64'd0);
    cmp("rst.smp_valid", 64'(valid0), 64'd0);
    cmp("rst.busy", 64'(busy0), 64'd0);
    cmp("rst.tries", 64'(tries0), 64'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    // seed 1, always-pass checker, two samples
    mode = 0; smp_ready = 1'b1; seed_load = 1'b1; seed_in = 32'd1;
    step();
    d0 = done_cnt[0]; d1 = done_cnt[1];
    seed_load = 1'b0; start = 1'b1; req_count = 16'd2;
    step();
    start = 1'b0;
    step(); step();
    cmp("t2.u0_not_yet_valid", 64'(valid0), 64'd0);
    step();
    cmp("t2.u0_valid", 64'(valid0), 64'd1);
    cmp("t2.u0_data", data0, 64'h8020_0003_C030_0002);
    step(); step();
    cmp("t2.u1_valid", 64'(valid1), 64'd1);
    cmp("t2.u1_data", {24'd0, data1}, 64'h0000_0003_C030_0002);
    wait_idle(100);
    cmp("t2.u0_done_pulses", 64'(done_cnt[0] - d0), 64'd1);
    cmp("t2.u1_done_pulses", 64'(done_cnt[1] - d1), 64'd1);

    // always-fail checker: retry budget exhausted
    mode = 1; f0 = fail_cnt[0]; f1 = fail_cnt[1]; vr = vrise_cnt[0];
    start = 1'b1; req_count = 16'd1;
    step();
    start = 1'b0;
    mx0 = 0; mx1 = 0; saw_v = 1'b0; n = 0;
    while ((busy0 || busy1 || n < 2) && n < 200) begin
      step(); n++;
      if (int'(tries0) > mx0) mx0 = int'(tries0);
      if (int'(tries1) > mx1) mx1 = int'(tries1);
      if (valid0 || valid1) saw_v = 1'b1;
    end
    cmp("t3.u0_max_tries", 64'(mx0), 64'd3);
    cmp("t3.u1_max_tries", 64'(mx1), 64'd5);
    cmp("t3.no_valid", 64'(saw_v), 64'd0);
    cmp("t3.u0_fail_pulses", 64'(fail_cnt[0] - f0), 64'd1);
    cmp("t3.u1_fail_pulses", 64'(fail_cnt[1] - f1), 64'd1);
    cmp("t3.busy", {62'd0, busy0, busy1}, 64'd0);

    // back-pressure in EMIT
    mode = 0; smp_ready = 1'b0; start = 1'b1; req_count = 16'd3; d0 = done_cnt[0];
    step();
    start = 1'b0;
    wait_valid0(50);
    hold_d = data0; hold_c = cand0; vr = vrise_cnt[0];
    for (int k = 0; k < 10; k++) begin
      step();
      cmp("t4.hold_valid", 64'(valid0), 64'd1);
      cmp("t4.hold_data", data0, hold_d);
      cmp("t4.hold_cand", cand0, hold_c);
    end
    smp_ready = 1'b1;
    step();
    smp_ready = 1'b0;
    cmp("t4.after_handshake", 64'(valid0), 64'd0);
    smp_ready = 1'b1;
    wait_idle(200);
    cmp("t4.u0_more_samples", 64'(vrise_cnt[0] - vr), 64'd2);
    cmp("t4.u0_done_pulses", 64'(done_cnt[0] - d0), 64'd1);

    // zero seed, seed priority over start, empty request, start while busy
    seed_load = 1'b1; seed_in = 32'd0; start = 1'b1; req_count = 16'd1;
    step();
    seed_load = 1'b0; start = 1'b0;
    cmp("t6.seed_beats_start", {62'd0, busy0, busy1}, 64'd0);
    d0 = done_cnt[0]; vr = vrise_cnt[0];
    start = 1'b1; req_count = 16'd0;
    step();
    start = 1'b0;
    step();
    cmp("t6.zero_req_busy", {62'd0, busy0, busy1}, 64'd0);
    cmp("t6.zero_req_done", 64'(done_cnt[0] - d0), 64'd0);
    start = 1'b1; req_count = 16'd1;
    step();
    start = 1'b0;
    step();
    start = 1'b1; req_count = 16'd5;
    step();
    start = 1'b0;
    wait_valid0(50);
    cmp("t6.default_seed_data", data0, 64'h5670_9012_2B38_4809);
    wait_idle(100);
    cmp("t6.busy_start_ignored", 64'(vrise_cnt[0] - vr), 64'd1);

    // asynchronous reset while a sample is on offer
    smp_ready = 1'b0; start = 1'b1; req_count = 16'd2;
    step();
    start = 1'b0;
    wait_valid0(50);
    #2 rst = 1'b1;
    #1;
    cmp("t1.cand0", cand0, 64'd0);
    cmp("t1.data0", data0, 64'd0);
    cmp("t1.valid0", 64'(valid0), 64'd0);
    cmp("t1.busy0", 64'(busy0), 64'd0);
    cmp("t1.tries0", 64'(tries0), 64'd0);
    cmp("t1.cand1", {24'd0, cand1}, 64'd0);
    cmp("t1.valid1", 64'(valid1), 64'd0);
    cmp("t1.busy1", 64'(busy1), 64'd0);
    step();
    rst = 1'b0;
    smp_ready = 1'b1; start = 1'b1; req_count = 16'd1;
    step();
    start = 1'b0;
    wait_valid0(50);
    cmp("t1.seed_after_reset", data0, 64'h5670_9012_2B38_4809);
    wait_idle(100);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if (!m_busy[0] && !m_busy[1] && $urandom_range(0, 7) == 0) mode = int'($urandom_range(0, 3));
      smp_ready = ($urandom_range(0, 3) != 0);
      start = ($urandom_range(0, 5) == 0);
      req_count = 16'($urandom_range(0, 3));
      seed_load = ($urandom_range(0, 19) == 0);
      seed_in = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom();
      step();
    end
    start = 1'b0; seed_load = 1'b0; smp_ready = 1'b1;
    wait_idle(600);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
